// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and helpers for the pipeline_register slice
package pipe_pkg;

    localparam int DEPTH_DEFAULT = 2;

    // Width needed to count 0..depth valid stages inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid+data slot of the pipeline chain
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int          N        = 32,
    parameter logic [N-1:0] init_val = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         load,
    input  logic         src_valid,
    input  logic [N-1:0] src_data,
    output logic         valid,
    output logic [N-1:0] data
);

    // Flush drops only the valid flag; data is kept so the output word stays quiet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= init_val;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= src_valid;
            if (src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipeline_register.sv
// rtl/pipeline_register.sv - DEPTH-stage stallable, flushable pipeline register; PIPE_OCCUPANCY_EN adds Occupancy
module pipeline_register
    import pipe_pkg::*;
#(
    parameter int           N        = 32,
    parameter int           DEPTH    = DEPTH_DEFAULT,
    parameter logic [N-1:0] init_val = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Flush,
    input  logic         InValid,
    output logic         InReady,
    input  logic [N-1:0] DataInput,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [N-1:0] DataOutput
`ifdef PIPE_OCCUPANCY_EN
    ,
    output logic [occ_width(DEPTH)-1:0] Occupancy
`endif
);

    logic [DEPTH-1:0] valid_q;
    logic [N-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0] rdy;

    // An empty stage always accepts, which is what collapses bubbles under stall.
    always_comb begin
        logic r;
        rdy = '0;
        r   = OutReady;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r      = ~valid_q[i] | r;
            rdy[i] = r;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic         src_valid;
        logic [N-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = InValid;
            assign src_data  = DataInput;
        end else begin : g_link
            assign src_valid = valid_q[i-1];
            assign src_data  = data_q[i-1];
        end

        pipe_stage #(
            .N        (N),
            .init_val (init_val)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (Flush),
            .load      (rdy[i]),
            .src_valid (src_valid),
            .src_data  (src_data),
            .valid     (valid_q[i]),
            .data      (data_q[i])
        );
    end

    assign InReady    = rdy[0] & ~Flush;
    assign OutValid   = valid_q[DEPTH-1] & ~Flush;
    assign DataOutput = data_q[DEPTH-1];

`ifdef PIPE_OCCUPANCY_EN
    localparam int OW = occ_width(DEPTH);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = InValid & InReady;
    assign out_xfer = OutValid & OutReady;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Occupancy <= '0;
        end else if (Flush) begin
            Occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            Occupancy <= Occupancy + OW'(1);
        end else if (out_xfer && !in_xfer) begin
            Occupancy <= Occupancy - OW'(1);
        end
    end
`endif

endmodule
